// File: rtl/ldpc_shift_pkg.sv
// Shared helpers for the QC-LDPC lifting rotator: stage/slice counts derived
// from the word width and grouping factor, plus a generic reference rotate.
package ldpc_shift_pkg;

   localparam int MAX_W = 512;
   typedef logic [MAX_W-1:0] wide_word_t;

   function automatic int nstg(input int maxz);
      return $clog2(maxz);
   endfunction

   // Grouping factor limited to 1..NSTG; larger values collapse to one slice.
   function automatic int clamp_r(input int maxz, input int r);
      int n;
      int res;
      n   = $clog2(maxz);
      res = r;
      if (r < 1) res = 1;
      if (r > n) res = n;
      return res;
   endfunction

   function automatic int nslice(input int maxz, input int r);
      int n;
      int rc;
      n  = nstg(maxz);
      rc = clamp_r(maxz, r);
      return (n + rc - 1) / rc;
   endfunction

   function automatic wide_word_t rot_right(input wide_word_t data, input int amt, input int width);
      wide_word_t res;
      int         a;
      res = '0;
      a   = amt % width;
      for (int i = 0; i < MAX_W; i++) begin
         if (i < width) res[i] = data[(i + a) % width];
      end
      return res;
   endfunction

endpackage

// File: rtl/pipelined_circular_shifter_if.sv
// Word/shift request and rotated-result bus between a memory-side master and
// the rotator.
interface pipelined_circular_shifter_if
   import ldpc_shift_pkg::*;
#(
   parameter int MAXZ = 81
) ();
   localparam int SW = nstg(MAXZ);

   logic            valid_in;
   logic [MAXZ-1:0] in_data;
   logic [SW-1:0]   shift_val;
   logic            valid_out;
   logic [MAXZ-1:0] out_data;

   modport master (
      output valid_in, in_data, shift_val,
      input  valid_out, out_data
   );

   modport slave (
      input  valid_in, in_data, shift_val,
      output valid_out, out_data
   );

endinterface

// File: rtl/rot_stage.sv
// One barrel level: rotates right by the constant AMT (within MAXZ bits)
// when en is set, otherwise passes the word through.
module rot_stage #(
   parameter int MAXZ = 81,
   parameter int AMT  = 1
) (
   input  logic            en,
   input  logic [MAXZ-1:0] d_in,
   output logic [MAXZ-1:0] d_out
);

   logic [MAXZ-1:0] rotated;

   for (genvar gi = 0; gi < MAXZ; gi++) begin : g_bit
      assign rotated[gi] = d_in[(gi + AMT) % MAXZ];
   end

   assign d_out = en ? rotated : d_in;

endmodule

// File: rtl/pipelined_circular_shifter.sv
// Pipelined circular right-rotator: NSTG power-of-two barrel levels grouped
// ROTATES_PER_CYCLE per register slice, optional input register.
module pipelined_circular_shifter
   import ldpc_shift_pkg::*;
#(
   parameter int MAXZ              = 81,
   parameter int ROTATES_PER_CYCLE = 1,
   parameter int IN_REG            = 0
) (
   input logic                         CLK,
   input logic                         rst_n,
   pipelined_circular_shifter_if.slave bus
);

   localparam int SW = nstg(MAXZ);
   localparam int R  = clamp_r(MAXZ, ROTATES_PER_CYCLE);
   localparam int NS = nslice(MAXZ, ROTATES_PER_CYCLE);

   logic            in_valid;
   logic [MAXZ-1:0] in_word;
   logic [SW-1:0]   in_shift;

   logic            valid_reg [NS];
   logic [MAXZ-1:0] data_reg  [NS];
   logic [SW-1:0]   shift_reg [NS];

   if (IN_REG != 0) begin : g_in_reg
      logic            in_valid_reg;
      logic [MAXZ-1:0] in_word_reg;
      logic [SW-1:0]   in_shift_reg;

      always_ff @(posedge CLK) begin
         if (rst_n) begin
            in_valid_reg <= 1'b0;
            in_word_reg  <= '0;
            in_shift_reg <= '0;
         end else begin
            in_valid_reg <= bus.valid_in;
            if (bus.valid_in) begin
               in_word_reg  <= bus.in_data;
               in_shift_reg <= bus.shift_val;
            end
         end
      end

      assign in_valid = in_valid_reg;
      assign in_word  = in_word_reg;
      assign in_shift = in_shift_reg;
   end else begin : g_in_direct
      assign in_valid = bus.valid_in;
      assign in_word  = bus.in_data;
      assign in_shift = bus.shift_val;
   end

   for (genvar gi = 0; gi < NS; gi++) begin : g_slice
      localparam int FIRST = gi * R;
      localparam int CNT   = ((SW - FIRST) < R) ? (SW - FIRST) : R;

      logic            v_i;
      logic [MAXZ-1:0] d_i;
      logic [SW-1:0]   s_i;
      logic [MAXZ-1:0] chain [CNT+1];

      if (gi == 0) begin : g_src_in
         assign v_i = in_valid;
         assign d_i = in_word;
         assign s_i = in_shift;
      end else begin : g_src_prev
         assign v_i = valid_reg[gi-1];
         assign d_i = data_reg[gi-1];
         assign s_i = shift_reg[gi-1];
      end

      assign chain[0] = d_i;

      // Global level FIRST+gj handles shift bit FIRST+gj, i.e. 2^(FIRST+gj) positions.
      for (genvar gj = 0; gj < CNT; gj++) begin : g_level
         rot_stage #(
            .MAXZ (MAXZ),
            .AMT  ((2 ** (FIRST + gj)) % MAXZ)
         ) u_rot (
            .en    (s_i[FIRST+gj]),
            .d_in  (chain[gj]),
            .d_out (chain[gj+1])
         );
      end

      always_ff @(posedge CLK) begin
         if (rst_n) begin
            valid_reg[gi] <= 1'b0;
            data_reg[gi]  <= '0;
            shift_reg[gi] <= '0;
         end else begin
            valid_reg[gi] <= v_i;
            if (v_i) begin
               data_reg[gi]  <= chain[CNT];
               shift_reg[gi] <= s_i;
            end
         end
      end
   end

   assign bus.valid_out = valid_reg[NS-1];
   assign bus.out_data  = data_reg[NS-1];

endmodule

// File: tb/tb_pipelined_circular_shifter.sv
// Directed/random bench for the rotator across several slice groupings and the
// input-registered configuration, all driven from one shared stimulus stream.
module tb_pipelined_circular_shifter;

   localparam int MAXZ = 81;
   localparam int SW   = 7;
   localparam int NI   = 7;
   localparam int HMAX = 1024;

   localparam int RS  [NI] = '{1, 2, 3, 4, 7, 1, 10};
   localparam int IR  [NI] = '{0, 0, 0, 0, 0, 1, 0};
   localparam int LAT [NI] = '{7, 4, 3, 2, 1, 8, 1};

   logic            CLK;
   logic            rst;
   logic            vi;
   logic [MAXZ-1:0] din;
   logic [SW-1:0]   sv;
   logic [MAXZ-1:0] cur_exp;

   logic [NI-1:0]   vo;
   logic [MAXZ-1:0] od [NI];

   logic            hv [HMAX];
   logic [MAXZ-1:0] hd [HMAX];
   int              cyc;
   int              last_rst;
   int              n_vec;
   int              n_fail;

   for (genvar gi = 0; gi < NI; gi++) begin : g_dut
      pipelined_circular_shifter_if #(.MAXZ(MAXZ)) bus ();

      assign bus.valid_in  = vi;
      assign bus.in_data   = din;
      assign bus.shift_val = sv;
      assign vo[gi]        = bus.valid_out;
      assign od[gi]        = bus.out_data;

      pipelined_circular_shifter #(
         .MAXZ              (MAXZ),
         .ROTATES_PER_CYCLE (RS[gi]),
         .IN_REG            (IR[gi])
      ) u_dut (
         .CLK   (CLK),
         .rst_n (rst),
         .bus   (bus.slave)
      );
   end

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   function automatic logic [MAXZ-1:0] ref_rot(input logic [MAXZ-1:0] d, input int s);
      logic [MAXZ-1:0] r;
      for (int i = 0; i < MAXZ; i++) r[i] = d[(i + s) % MAXZ];
      return r;
   endfunction

   // Advance one edge, log what was presented, then check every instance.
   task automatic tick();
      @(posedge CLK);
      cyc++;
      hv[cyc] = vi && !rst;
      hd[cyc] = cur_exp;
      if (rst) last_rst = cyc;
      #1;
      for (int k = 0; k < NI; k++) begin
         int   src;
         logic ev;
         src = cyc - LAT[k] + 1;
         ev  = 1'b0;
         if (src >= 1) ev = hv[src] && (last_rst <= src);
         n_vec++;
         assert (vo[k] === ev) else begin
            n_fail++;
            $error("FAIL valid_out inst%0d cyc%0d: observed %b expected %b", k, cyc, vo[k], ev);
         end
         if (ev) begin
            n_vec++;
            assert (od[k] === hd[src]) else begin
               n_fail++;
               $error("FAIL out_data inst%0d cyc%0d: observed %h expected %h", k, cyc, od[k], hd[src]);
            end
         end else if (last_rst == cyc) begin
            n_vec++;
            assert (od[k] === '0) else begin
               n_fail++;
               $error("FAIL reset_data inst%0d cyc%0d: observed %h expected 0", k, cyc, od[k]);
            end
         end
      end
   endtask

   task automatic drive(input logic v, input logic [MAXZ-1:0] d, input logic [SW-1:0] s,
                        input logic [MAXZ-1:0] e);
      vi      = v;
      din     = d;
      sv      = s;
      cur_exp = e;
      tick();
   endtask

   task automatic idle(input int n);
      vi = 1'b0;
      repeat (n) tick();
   endtask

   initial begin
      logic [MAXZ-1:0] rd;
      int              rs;

      cyc      = 0;
      last_rst = 0;
      n_vec    = 0;
      n_fail   = 0;
      rst      = 1'b1;
      vi       = 1'b0;
      din      = '0;
      sv       = '0;
      cur_exp  = '0;
      for (int i = 0; i < HMAX; i++) begin
         hv[i] = 1'b0;
         hd[i] = '0;
      end

      // Reset: valid_in presented during the last two reset cycles must be ignored.
      idle(3);
      drive(1'b1, 81'h5, 7'd1, 81'h0);
      drive(1'b1, 81'h7, 7'd2, 81'h0);
      rst = 1'b0;
      idle(2);

      drive(1'b1, 81'h1, 7'd1, 81'h1_0000_0000_0000_0000_0000);
      idle(9);
      drive(1'b1, 81'h1_0000_0000_0000_0000_0003, 7'd0, 81'h1_0000_0000_0000_0000_0003);
      idle(9);
      drive(1'b1, 81'h1, 7'd100, 81'h0_4000_0000_0000_0000);
      idle(9);
      drive(1'b1, 81'h3, 7'd2, 81'h1_8000_0000_0000_0000_0000);
      idle(9);
      drive(1'b1, 81'h1_2345_6789_ABCD_EF01_2345, 7'd4, 81'h0_B234_5678_9ABC_DEF0_1234);
      idle(9);

      // Back-to-back burst, s = 0..9 on a single set bit, then the 127 == 46 case.
      drive(1'b1, 81'h1, 7'd0, 81'h1);
      for (int k = 1; k < 10; k++) drive(1'b1, 81'h1, SW'(k), 81'h1 << (MAXZ - k));
      drive(1'b1, 81'h1, 7'd127, 81'h8_0000_0000);
      idle(10);

      for (int n = 0; n < 40; n++) begin
         rd = MAXZ'({$urandom(), $urandom(), $urandom()});
         rs = int'($urandom_range(80, 0));
         drive(1'b1, rd, SW'(rs), ref_rot(rd, rs));
         idle(int'($urandom_range(2, 0)));
      end
      idle(10);

      // Three words in flight, then reset: nothing from them may emerge.
      drive(1'b1, 81'hA5, 7'd3, ref_rot(81'hA5, 3));
      drive(1'b1, 81'h5A, 7'd5, ref_rot(81'h5A, 5));
      drive(1'b1, 81'hFF, 7'd7, ref_rot(81'hFF, 7));
      rst = 1'b1;
      idle(2);
      rst = 1'b0;
      idle(10);
      drive(1'b1, 81'h1, 7'd80, 81'h2);
      idle(10);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
